// File: rtl/dcache_axi_rd_pkg.sv
// Shared encodings for the data-cache AXI read engine: request types, FSM states,
// AXI burst constants and the type -> burst shape helpers.
package dcache_axi_rd_pkg;

    typedef enum logic [1:0] {
        RD_WORD   = 2'b00,
        RD_LINE16 = 2'b01,
        RD_LINE32 = 2'b10,
        RD_RSVD   = 2'b11
    } rd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // The reserved encoding behaves as a 32-byte line everywhere.
    function automatic logic [7:0] burst_len(input rd_type_e t);
        case (t)
            RD_WORD:   burst_len = 8'd0;
            RD_LINE16: burst_len = 8'd3;
            default:   burst_len = 8'd7;
        endcase
    endfunction

    function automatic logic [31:0] burst_addr(input rd_type_e t, input logic [31:0] a);
        case (t)
            RD_WORD:   burst_addr = a;
            RD_LINE16: burst_addr = {a[31:4], 4'b0};
            default:   burst_addr = {a[31:5], 5'b0};
        endcase
    endfunction

endpackage

// File: rtl/dcache_axi_rd.sv
// Single-outstanding AXI read engine for D-cache refills and uncached loads.
// Assembles up to eight 32-bit beats into a 256-bit return buffer.
module dcache_axi_rd
    import dcache_axi_rd_pkg::*;
#(
    parameter logic [3:0] RD_ID = 4'd0
) (
    input  logic         clk,
    input  logic         resetn,

    input  logic         rd_req,
    input  logic [1:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,

    output logic         ret_valid,
    output logic [255:0] ret_data,
    output logic         ret_half,

    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,

    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    state_e         state_q, state_d;
    rd_type_e       type_q, type_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     beat_q, beat_d;
    logic           ret_valid_q, ret_valid_d;
    logic           ret_half_q, ret_half_d;
    logic [255:0]   ret_data_q, ret_data_d;

    logic [7:0]     len;
    logic           beat_take;
    logic           last_beat;

    // Completion is purely counter-based; these response fields are not consulted.
    logic           unused_axi;
    assign unused_axi = ^{rid, rresp, rlast};

    assign len       = burst_len(type_q);
    assign beat_take = (state_q == ST_R) && rvalid;
    assign last_beat = ({5'd0, beat_q} == len);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            type_q      <= RD_WORD;
            addr_q      <= '0;
            beat_q      <= '0;
            ret_valid_q <= 1'b0;
            ret_half_q  <= 1'b0;
            ret_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            ret_valid_q <= ret_valid_d;
            ret_half_q  <= ret_half_d;
            ret_data_q  <= ret_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rd_req)                  state_d = ST_AR;
            ST_AR:   if (arready)                 state_d = ST_R;
            ST_R:    if (beat_take && last_beat)  state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        type_d      = type_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        ret_data_d  = ret_data_q;
        ret_valid_d = 1'b0;
        ret_half_d  = 1'b0;

        if (state_q == ST_IDLE && rd_req) begin
            type_d = rd_type_e'(rd_type);
            addr_d = rd_addr;
        end

        if (state_q == ST_AR && arready) begin
            beat_d = '0;
        end

        if (beat_take) begin
            ret_data_d[{beat_q, 5'b0} +: 32] = rdata;
            beat_d = beat_q + 3'd1;
            if (last_beat) begin
                ret_valid_d = 1'b1;
            end else if (len == 8'd7 && beat_q == 3'd3) begin
                // Lower half of a 32-byte line is released early for critical-word use.
                ret_valid_d = 1'b1;
                ret_half_d  = 1'b1;
            end
        end
    end

    assign rd_rdy    = (state_q == ST_IDLE);
    assign arvalid   = (state_q == ST_AR);
    assign rready    = (state_q == ST_R);
    assign arid      = RD_ID;
    assign araddr    = burst_addr(type_q, addr_q);
    assign arlen     = len;
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;
    assign ret_valid = ret_valid_q;
    assign ret_half  = ret_half_q;
    assign ret_data  = ret_data_q;

endmodule

// File: tb/tb_dcache_axi_rd.sv
// Directed bench for dcache_axi_rd: AR and return expectations are queued as
// stimulus is driven and checked by negedge monitors.
module tb_dcache_axi_rd;

    logic         clk;
    logic         resetn;
    logic         rd_req;
    logic [1:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         ret_half;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    dcache_axi_rd #(.RD_ID(4'hA)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_data  (ret_data),
        .ret_half  (ret_half),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         half;
        logic [255:0] data;
    } ret_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ret_t         ret_q[$];
    ar_t          ar_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] model_buf = '0;
    int           beat_k;
    int           cur_len;
    logic         cur_8;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (arvalid && arready) begin
            if (ar_q.size() == 0) begin
                chk("ar_unexpected", 1'b1, 1'b0);
            end else begin
                ar_t e;
                e = ar_q.pop_front();
                chk("araddr", araddr, e.addr);
                chk("arlen", arlen, e.len);
                chk("arsize", arsize, 3'b010);
                chk("arburst", arburst, 2'b01);
                chk("arid", arid, 4'hA);
            end
        end
        if (ret_valid) begin
            if (ret_q.size() == 0) begin
                chk("ret_unexpected", 1'b1, 1'b0);
            end else begin
                ret_t r;
                r = ret_q.pop_front();
                chk("ret_half", ret_half, r.half);
                chk("ret_data", ret_data, r.data);
            end
        end else if (ret_half) begin
            chk("half_without_valid", ret_half, 1'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge with the DUT idle.
    task automatic start_req(input logic [1:0] t, input logic [31:0] a,
                             input logic [31:0] exp_addr, input logic [7:0] exp_len);
        rd_req  = 1'b1;
        rd_type = t;
        rd_addr = a;
        @(negedge clk);
        chk("rd_rdy_at_req", rd_rdy, 1'b1);
        ar_q.push_back('{exp_addr, exp_len});
        @(posedge clk);
        #1 rd_req = 1'b0;
        beat_k  = 0;
        cur_len = int'(exp_len);
        cur_8   = (exp_len == 8'd7);
    endtask

    task automatic ar_go();
        @(negedge clk);
        chk("arvalid_hs", arvalid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        int   n;
        logic exp_pulse;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rvalid = 1'b1;
        rdata  = d;
        n = 0;
        @(negedge clk);
        while (!rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rready_wait", rready, 1'b1);
        model_buf[32*beat_k +: 32] = d;
        exp_pulse = (beat_k == cur_len) || (cur_8 && beat_k == 3);
        if (exp_pulse) ret_q.push_back('{(beat_k != cur_len), model_buf});
        @(posedge clk);
        #1 rvalid = 1'b0;
        rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("ret_valid_timing", ret_valid, exp_pulse);
        if (beat_k == cur_len) chk("rd_rdy_at_done", rd_rdy, 1'b1);
        beat_k++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_rdy"}, rd_rdy, 1'b1);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_ret_valid"}, ret_valid, 1'b0);
        chk({tag, "_ret_half"}, ret_half, 1'b0);
        chk({tag, "_ret_data"}, ret_data, 256'd0);
        chk({tag, "_araddr"}, araddr, 32'd0);
        chk({tag, "_arlen"}, arlen, 8'd0);
    endtask

    initial begin
        resetn  = 1'b0;
        rd_req  = 1'b0;
        rd_type = 2'b00;
        rd_addr = '0;
        arready = 1'b0;
        rid     = 4'h3;
        rdata   = '0;
        rresp   = 2'b10;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        #3;
        chk_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;

        // uncached word, arready already high
        arready = 1'b1;
        start_req(2'b00, 32'h1FC0_0004, 32'h1FC0_0004, 8'd0);
        ar_go();
        rlast = 1'b1;
        send_beat(32'hDEAD_BEEF, 0);
        rlast = 1'b0;
        chk("word_data", ret_data[31:0], 32'hDEAD_BEEF);

        // 16-byte line
        start_req(2'b01, 32'h0000_1238, 32'h0000_1230, 8'd3);
        ar_go();
        send_beat(32'h11, 0);
        send_beat(32'h22, 0);
        send_beat(32'h33, 0);
        send_beat(32'h44, 0);
        chk("line16_data", ret_data[127:0], {32'h44, 32'h33, 32'h22, 32'h11});

        // 32-byte line with 2-cycle rvalid gaps
        start_req(2'b10, 32'h8000_007C, 32'h8000_0060, 8'd7);
        ar_go();
        for (int i = 1; i <= 8; i++) send_beat(i, 1);
        chk("line32_top", ret_data[255:224], 32'd8);
        chk("line32_unwritten_kept", ret_data[127:96], 32'd4);

        // rvalid while idle must be ignored
        rvalid = 1'b1;
        rdata  = 32'hCAFE_F00D;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rready", rready, 1'b0);
        end
        @(posedge clk);
        #1 rvalid = 1'b0;
        chk("idle_no_write", ret_data, model_buf);

        // arready held low: address channel must be stable
        arready = 1'b0;
        start_req(2'b01, 32'h0000_ABCD, 32'h0000_ABC0, 8'd3);
        repeat (5) begin
            @(negedge clk);
            chk("stall_arvalid", arvalid, 1'b1);
            chk("stall_araddr", araddr, 32'h0000_ABC0);
            chk("stall_arlen", arlen, 8'd3);
            chk("stall_rd_rdy", rd_rdy, 1'b0);
        end
        @(posedge clk);
        #1 arready = 1'b1;
        ar_go();
        send_beat(32'hA0A0_0001, 0);
        send_beat(32'hA0A0_0002, 2);
        send_beat(32'hA0A0_0003, 0);
        send_beat(32'hA0A0_0004, 0);

        // back-to-back: new request accepted in the completion-pulse cycle
        start_req(2'b00, 32'h0000_0100, 32'h0000_0100, 8'd0);
        ar_go();
        rd_req  = 1'b1;
        rd_type = 2'b00;
        rd_addr = 32'h2000_0008;
        ar_q.push_back('{32'h2000_0008, 8'd0});
        send_beat(32'h1234_5678, 0);
        rd_req  = 1'b0;
        beat_k  = 0;
        cur_len = 0;
        cur_8   = 1'b0;
        @(negedge clk);
        chk("b2b_arvalid", arvalid, 1'b1);
        @(posedge clk);
        #1;
        send_beat(32'h0BAD_CAFE, 0);
        chk("b2b_data", ret_data[31:0], 32'h0BAD_CAFE);

        // reserved type behaves as 32-byte line
        start_req(2'b11, 32'h0000_0044, 32'h0000_0040, 8'd7);
        ar_go();
        for (int i = 0; i < 8; i++) send_beat(32'h5500_0000 + i, 0);

        // reset in the middle of an 8-beat burst
        start_req(2'b10, 32'h4000_0010, 32'h4000_0000, 8'd7);
        ar_go();
        send_beat(32'h7777_0001, 0);
        send_beat(32'h7777_0002, 0);
        rvalid = 1'b1;
        rdata  = 32'h7777_0003;
        resetn = 1'b0;
        #2;
        chk_reset_outputs("midr");
        model_buf = '0;
        @(posedge clk);
        #1 resetn = 1'b1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("midr_rd_rdy_after", rd_rdy, 1'b1);
        repeat (3) @(negedge clk);
        chk("midr_no_write", ret_data, 256'd0);

        // reset during the address phase
        arready = 1'b0;
        @(posedge clk);
        #1;
        start_req(2'b01, 32'h0000_0020, 32'h0000_0020, 8'd3);
        @(negedge clk);
        chk("midar_arvalid", arvalid, 1'b1);
        resetn = 1'b0;
        ar_q.delete();
        #2;
        chk("midar_arvalid_rst", arvalid, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("midar_rd_rdy_after", rd_rdy, 1'b1);
        repeat (3) @(negedge clk);

        chk("ret_q_drained", ret_q.size(), 0);
        chk("ar_q_drained", ar_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
